// File: rtl/bus_adapter_pkg.sv
// Shared types and constants for the bus adapter family.
// No logic, no latency.
// No flow control.
package bus_adapter_pkg;

    localparam int REG_DATA_W = 32;
    localparam logic [REG_DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        RESP      = 2'd2
    } state_t;

    // A single channel still needs one select bit so that the slices stay legal.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Counts enabled cycles and flags the TIMEOUT-th one.
// expired is combinational from the count; the count updates one edge later.
// No flow control; clear wins over en.
module bus_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // cnt holds the number of enabled cycles already completed.
    assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_adapter_mux.sv
// Bus slave port fanned out to N_CH register blocks, one outstanding read with timeout.
// Writes reach the register block 1 cycle after the strobe; reads complete 2 cycles after the strobe at best.
// One read in flight; requests while busy or in RESP are dropped and flagged with bus_err.
module bus_adapter_mux
    import bus_adapter_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ADDR_W     = 8,
    parameter int BUS_ADDR_W = 32,
    parameter int TIMEOUT    = 16,
    parameter logic [REG_DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         bus_wr,
    input  logic                         bus_rd,
    input  logic [BUS_ADDR_W-1:0]        bus_addr,
    input  logic [REG_DATA_W-1:0]        bus_data_i,
    output logic [REG_DATA_W-1:0]        bus_data_o,
    output logic                         bus_rvalid,
    output logic                         bus_err,
    output logic                         bus_busy,
    output logic [N_CH-1:0]              reg_wr,
    output logic [N_CH-1:0]              reg_rd,
    output logic [ADDR_W-1:0]            reg_addr,
    output logic [REG_DATA_W-1:0]        reg_data_i,
    input  logic [N_CH*REG_DATA_W-1:0]   reg_data_o,
    input  logic [N_CH-1:0]              reg_rvalid,
    output logic [15:0]                  err_cnt
);
    localparam int CH_W  = safe_clog2(N_CH);
    localparam int DEC_W = ADDR_W + CH_W;

    state_t                  state;
    logic [CH_W-1:0]         ch;
    logic [CH_W-1:0]         sel;
    logic [ADDR_W-1:0]       off;
    logic [N_CH-1:0]         ch_oh;
    logic [REG_DATA_W-1:0]   ch_data [N_CH];
    logic                    unmapped;
    logic                    wr_ok;
    logic                    rd_ok;
    logic                    rd_err;
    logic                    rsp_hit;
    logic                    tmo;
    logic                    expired;
    logic                    err_nxt;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        assign ch_data[k] = reg_data_o[REG_DATA_W*k +: REG_DATA_W];
    end

    assign ch       = bus_addr[DEC_W-1:ADDR_W];
    assign off      = bus_addr[ADDR_W-1:0];
    assign ch_oh    = (N_CH)'(1'b1) << ch;
    assign unmapped = ({1'b0, ch} >= (CH_W+1)'(N_CH)) || ((bus_addr >> DEC_W) != '0);

    assign rsp_hit  = (state == READ_WAIT) && reg_rvalid[sel];
    assign tmo      = (state == READ_WAIT) && !reg_rvalid[sel] && expired;

    bus_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != READ_WAIT),
        .en      (state == READ_WAIT),
        .expired (expired)
    );

    always_comb begin
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        rd_err  = 1'b0;
        err_nxt = tmo;
        if (bus_wr && bus_rd) begin
            err_nxt = 1'b1;
        end else if (bus_wr || bus_rd) begin
            if (state != IDLE) begin
                err_nxt = 1'b1;
            end else if (unmapped) begin
                err_nxt = 1'b1;
                rd_err  = bus_rd;
            end else begin
                wr_ok = bus_wr;
                rd_ok = bus_rd;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= '0;
            bus_data_o <= '0;
            bus_rvalid <= 1'b0;
            bus_err    <= 1'b0;
            bus_busy   <= 1'b0;
            reg_wr     <= '0;
            reg_rd     <= '0;
            reg_addr   <= '0;
            reg_data_i <= '0;
            err_cnt    <= '0;
        end else begin
            reg_wr     <= '0;
            reg_rd     <= '0;
            bus_rvalid <= 1'b0;
            bus_err    <= err_nxt;
            if (err_nxt && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    if (wr_ok) begin
                        reg_wr     <= ch_oh;
                        reg_addr   <= off;
                        reg_data_i <= bus_data_i;
                    end else if (rd_ok) begin
                        reg_rd   <= ch_oh;
                        reg_addr <= off;
                        sel      <= ch;
                        bus_busy <= 1'b1;
                        state    <= READ_WAIT;
                    end else if (rd_err) begin
                        bus_rvalid <= 1'b1;
                        bus_data_o <= ERR_DATA;
                    end
                end
                READ_WAIT: begin
                    if (rsp_hit) begin
                        bus_rvalid <= 1'b1;
                        bus_data_o <= ch_data[sel];
                        state      <= RESP;
                    end else if (tmo) begin
                        bus_rvalid <= 1'b1;
                        bus_data_o <= ERR_DATA;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus_busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_adapter_mux.sv
// Directed bench for bus_adapter_mux with N_CH=4, ADDR_W=8, TIMEOUT=16.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_adapter_mux;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_wr;
    logic          bus_rd;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_data_i;
    logic [31:0]   bus_data_o;
    logic          bus_rvalid;
    logic          bus_err;
    logic          bus_busy;
    logic [3:0]    reg_wr;
    logic [3:0]    reg_rd;
    logic [7:0]    reg_addr;
    logic [31:0]   reg_data_i;
    logic [127:0]  reg_data_o;
    logic [3:0]    reg_rvalid;
    logic [15:0]   err_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_adapter_mux #(
        .N_CH       (4),
        .ADDR_W     (8),
        .BUS_ADDR_W (32),
        .TIMEOUT    (16),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_addr   (bus_addr),
        .bus_data_i (bus_data_i),
        .bus_data_o (bus_data_o),
        .bus_rvalid (bus_rvalid),
        .bus_err    (bus_err),
        .bus_busy   (bus_busy),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_data_i (reg_data_i),
        .reg_data_o (reg_data_o),
        .reg_rvalid (reg_rvalid),
        .err_cnt    (err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_wr     = 1'b0;
        bus_rd     = 1'b0;
        reg_rvalid = '0;
    endtask

    initial begin
        reset      = 1'b1;
        bus_addr   = '0;
        bus_data_i = '0;
        reg_data_o = '0;
        idle_inputs();
        tick();
        tick();
        chk("rst_rvalid", 32'(bus_rvalid), 32'd0);
        chk("rst_busy",   32'(bus_busy),   32'd0);
        chk("rst_err",    32'(bus_err),    32'd0);
        chk("rst_data",   bus_data_o,      32'd0);
        chk("rst_regwr",  32'(reg_wr),     32'd0);
        chk("rst_cnt",    32'(err_cnt),    32'd0);
        reset = 1'b0;
        tick();

        // Write to channel 3, offset 0x05.
        bus_wr = 1'b1; bus_addr = 32'h0000_0305; bus_data_i = 32'h1234_5678;
        tick();
        idle_inputs();
        chk("wr_strobe", 32'(reg_wr),   32'h8);
        chk("wr_addr",   32'(reg_addr), 32'h05);
        chk("wr_data",   reg_data_i,    32'h1234_5678);
        chk("wr_noerr",  32'(bus_err),  32'd0);
        chk("wr_nobusy", 32'(bus_busy), 32'd0);
        tick();
        chk("wr_pulse",  32'(reg_wr),   32'd0);

        // Two-cycle read from channel 1.
        bus_rd = 1'b1; bus_addr = 32'h0000_0102;
        tick();
        idle_inputs();
        chk("rd_strobe", 32'(reg_rd),     32'h2);
        chk("rd_addr",   32'(reg_addr),   32'h02);
        chk("rd_busy1",  32'(bus_busy),   32'd1);
        chk("rd_early",  32'(bus_rvalid), 32'd0);
        reg_rvalid = 4'b0010; reg_data_o[63:32] = 32'hCAFE_0001;
        tick();
        reg_rvalid = '0;
        chk("rd_rvalid", 32'(bus_rvalid), 32'd1);
        chk("rd_data",   bus_data_o,      32'hCAFE_0001);
        chk("rd_noerr",  32'(bus_err),    32'd0);
        chk("rd_busy2",  32'(bus_busy),   32'd1);
        tick();
        chk("rd_done",   32'(bus_rvalid), 32'd0);
        chk("rd_idle",   32'(bus_busy),   32'd0);
        chk("rd_hold",   bus_data_o,      32'hCAFE_0001);

        // Silent channel 2: error response after 16 cycles in READ_WAIT.
        bus_rd = 1'b1; bus_addr = 32'h0000_0200;
        tick();
        idle_inputs();
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_before", 32'(bus_rvalid), 32'd0);
        chk("tmo_busy",   32'(bus_busy),   32'd1);
        tick();
        chk("tmo_rvalid", 32'(bus_rvalid), 32'd1);
        chk("tmo_err",    32'(bus_err),    32'd1);
        chk("tmo_data",   bus_data_o,      32'hDEAD_BEEF);
        chk("tmo_cnt",    32'(err_cnt),    32'd1);
        tick();
        tick();
        tick();
        reg_rvalid = 4'b0100; reg_data_o[95:64] = 32'h2222_2222;
        tick();
        reg_rvalid = '0;
        chk("late_rvalid", 32'(bus_rvalid), 32'd0);
        chk("late_err",    32'(bus_err),    32'd0);
        chk("late_data",   bus_data_o,      32'hDEAD_BEEF);
        chk("late_cnt",    32'(err_cnt),    32'd1);

        // Unmapped write, protocol violation, unmapped read.
        bus_wr = 1'b1; bus_addr = 32'h0001_0000; bus_data_i = 32'h5555_5555;
        tick();
        idle_inputs();
        chk("unm_wr_err", 32'(bus_err),    32'd1);
        chk("unm_wr_rv",  32'(bus_rvalid), 32'd0);
        chk("unm_wr_reg", 32'(reg_wr),     32'd0);
        tick();
        chk("unm_wr_pls", 32'(bus_err),    32'd0);
        bus_wr = 1'b1; bus_rd = 1'b1; bus_addr = 32'h0000_0100;
        tick();
        idle_inputs();
        chk("proto_err",  32'(bus_err),        32'd1);
        chk("proto_reg",  32'({reg_wr, reg_rd}), 32'd0);
        chk("proto_rv",   32'(bus_rvalid),     32'd0);
        chk("proto_busy", 32'(bus_busy),       32'd0);
        chk("proto_cnt",  32'(err_cnt),        32'd3);
        tick();
        bus_rd = 1'b1; bus_addr = 32'h0000_0400;
        tick();
        idle_inputs();
        chk("unm_rd_rv",   32'(bus_rvalid), 32'd1);
        chk("unm_rd_err",  32'(bus_err),    32'd1);
        chk("unm_rd_data", bus_data_o,      32'hDEAD_BEEF);
        chk("unm_rd_reg",  32'(reg_rd),     32'd0);
        chk("unm_rd_cnt",  32'(err_cnt),    32'd4);
        tick();

        // Read channel 3 at the top offset; second read and stray ch0 valid while busy.
        bus_rd = 1'b1; bus_addr = 32'h0000_03FF;
        tick();
        chk("ch3_strobe", 32'(reg_rd),   32'h8);
        chk("ch3_addr",   32'(reg_addr), 32'hFF);
        bus_rd = 1'b1; bus_addr = 32'h0000_0001;
        reg_rvalid = 4'b0001; reg_data_o[31:0] = 32'h0000_AAAA;
        tick();
        idle_inputs();
        chk("busy_drop_err", 32'(bus_err),    32'd1);
        chk("busy_drop_rd",  32'(reg_rd),     32'd0);
        chk("busy_no_rv",    32'(bus_rvalid), 32'd0);
        chk("busy_still",    32'(bus_busy),   32'd1);
        reg_rvalid = 4'b1000; reg_data_o[127:96] = 32'h3333_0003;
        tick();
        idle_inputs();
        chk("ch3_rvalid", 32'(bus_rvalid), 32'd1);
        chk("ch3_data",   bus_data_o,      32'h3333_0003);
        chk("ch3_noerr",  32'(bus_err),    32'd0);
        bus_wr = 1'b1; bus_addr = 32'h0000_0010; bus_data_i = 32'h7777_7777;
        tick();
        idle_inputs();
        chk("resp_drop_err", 32'(bus_err),  32'd1);
        chk("resp_drop_wr",  32'(reg_wr),   32'd0);
        chk("resp_idle",     32'(bus_busy), 32'd0);
        chk("resp_cnt",      32'(err_cnt),  32'd6);
        tick();

        // Reset in the middle of a read.
        bus_rd = 1'b1; bus_addr = 32'h0000_0110;
        tick();
        idle_inputs();
        tick();
        chk("mid_busy", 32'(bus_busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("mrst_busy", 32'(bus_busy),   32'd0);
        chk("mrst_rd",   32'(reg_rd),     32'd0);
        chk("mrst_addr", 32'(reg_addr),   32'd0);
        chk("mrst_wdat", reg_data_i,      32'd0);
        chk("mrst_data", bus_data_o,      32'd0);
        chk("mrst_cnt",  32'(err_cnt),    32'd0);
        tick();
        reset = 1'b0;
        reg_rvalid = 4'b0010; reg_data_o[63:32] = 32'h1111_1111;
        tick();
        reg_rvalid = '0;
        chk("post_rv",   32'(bus_rvalid), 32'd0);
        chk("post_busy", 32'(bus_busy),   32'd0);
        tick();
        chk("post_rv2",  32'(bus_rvalid), 32'd0);
        chk("post_data", bus_data_o,      32'd0);
        chk("post_cnt",  32'(err_cnt),    32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
